cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- WORD_SIZE, 32, address and data width.
- MISS_LATENCY, 8, cycles waited after a miss before read data is valid (legal 1..255).
- FLUSH_LATENCY, 16, cycles cache_flush is held before flush_done (legal 1..255).

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst, in, 1, reset; asynchronous and active-high.
- req0_valid, in, 1, requester 0 has an access pending.
- req0_write, in, 1, requester 0 access is a store (0 = load).
- req0_addr, in, WORD_SIZE, requester 0 byte address.
- req0_wdata, in, WORD_SIZE, requester 0 store data.
- req0_ready, out, 1, requester 0 access accepted this cycle.
- resp0_valid, out, 1, one-cycle completion pulse for requester 0.
- resp0_rdata, out, WORD_SIZE, load data for requester 0.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata: the same as the port-0 signals, for requester 1.
- flush_req, in, 1, halt-time request to write back all dirty lines.
- flush_done, out, 1, one-cycle pulse marking the end of a flush.
- busy, out, 1, high whenever the FSM is not in IDLE.
- cache_addr, out, WORD_SIZE, address to the data cache.
- cache_readable, out, 1, data cache read strobe.
- cache_writable, out, 1, data cache write strobe.
- cache_wdata, out, WORD_SIZE, data cache write data.
- cache_rdata, in, WORD_SIZE, data cache read data.
- cache_hit, in, 1, data cache hit indication.
- cache_flush, out, 1, data cache flush level.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, LOOKUP, MISS_WAIT, RESP and FLUSH, all registered.

REQ-004 In IDLE with flush_req=1, the FSM SHALL go to FLUSH, assert no req*_ready, and give flush priority over both requesters.

REQ-005 In IDLE with flush_req=0, reqN_ready SHALL be combinational and high only for the granted valid requester.
- A transfer occurs when reqN_valid and reqN_ready are both high.

REQ-006 Arbitration SHALL be round-robin using a last_grant bit.
- When both requesters are valid, the port not equal to last_grant wins.
- A single valid requester wins unconditionally.
- last_grant updates on every transfer.

REQ-007 On a transfer, the block SHALL register addr, write, wdata and the granted port number, and go to ISSUE.

REQ-008 In ISSUE, the block SHALL drive cache_addr and cache_wdata from the captured values.
- cache_readable (load) or cache_writable (store) SHALL be 1 for exactly this one cycle; both SHALL be 0 in every other state.

REQ-009 In LOOKUP, the block SHALL sample cache_hit.
- Hit, or any store: capture cache_rdata (loads only) and go to RESP.
- Load miss: load a counter with MISS_LATENCY and go to MISS_WAIT.

REQ-010 In MISS_WAIT, the counter SHALL decrement each cycle.
- When it reaches 1, capture cache_rdata and go to RESP.
- cache_addr SHALL stay stable throughout.

REQ-011 In RESP, the block SHALL pulse resp_valid of the captured port for one cycle and return to IDLE.
- respN_rdata SHALL hold the load data until that port's next response.
- Stores SHALL drive respN_rdata to 0.

REQ-012 Latency from the transfer cycle T:
- Hit load or store: resp at T+3.
- Load miss: resp at T+3+MISS_LATENCY.
- A new transfer is possible no earlier than T+4 (hit) or T+4+MISS_LATENCY (miss).

REQ-013 In FLUSH, cache_flush SHALL be 1 for exactly FLUSH_LATENCY cycles.
- On the last cycle, cache_flush drops and flush_done pulses.
- The FSM then returns to IDLE.
- A flush_req still high in that IDLE cycle SHALL start a new flush.

REQ-014 A flush_req arriving while not in IDLE SHALL wait until the current access reaches IDLE; it SHALL never abort an access.

REQ-015 At most one access or flush SHALL be outstanding.
- req*_ready SHALL be 0 in every state except IDLE.
- reqN_valid deasserted before acceptance SHALL be ignored, with no side effects.

Reset
REQ-016 While rst=1, and immediately on its assertion, the block SHALL enter IDLE.
- All outputs SHALL be 0: req*_ready (forced 0 during reset), resp*_valid, resp*_rdata, flush_done, busy, cache_addr, cache_readable, cache_writable, cache_wdata, cache_flush.
- last_grant SHALL be set to 1, so port 0 wins the first contention.
- The miss counter SHALL be cleared.

REQ-017 Reset during any state SHALL abort the operation with no response or flush_done pulse.
- Cache strobes and cache_flush SHALL drop in the same cycle rst rises.

Verification
REQ-018 Hit load: req0 load addr 0x80, cache_hit=1, cache_rdata=0xDEADBEEF -> cache_readable high at T+1 only, resp0_valid at T+3, resp0_rdata=0xDEADBEEF.

REQ-019 Miss load with MISS_LATENCY=8: req1 load addr 0x400, cache_hit=0 -> resp1_valid at T+11 with the cache_rdata of cycle T+10, and busy high T+1..T+11.

REQ-020 Contention: both valid after reset -> port 0 granted first and port 1 second, with back-to-back accepts alternating 0,1,0,1.

REQ-021 Store: req0 store addr 0x10, data 0x12345678 -> cache_writable one cycle with cache_wdata=0x12345678, resp0_valid at T+3, resp0_rdata=0.

REQ-022 Flush priority: flush_req and req0_valid together in IDLE -> cache_flush high for 16 cycles and flush_done pulses, with req0 accepted only afterward.

REQ-023 Reset mid-miss: rst asserted during MISS_WAIT -> all outputs 0 immediately, no resp pulse, next access after rst behaves as REQ-018.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bus bundle between two requesters, the data cache and the cache arbiter.
// slave = arbiter side, master = requester/cache side.
interface cache_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req0_valid;
  logic                 req0_write;
  logic [WORD_SIZE-1:0] req0_addr;
  logic [WORD_SIZE-1:0] req0_wdata;
  logic                 req0_ready;
  logic                 resp0_valid;
  logic [WORD_SIZE-1:0] resp0_rdata;

  logic                 req1_valid;
  logic                 req1_write;
  logic [WORD_SIZE-1:0] req1_addr;
  logic [WORD_SIZE-1:0] req1_wdata;
  logic                 req1_ready;
  logic                 resp1_valid;
  logic [WORD_SIZE-1:0] resp1_rdata;

  logic                 flush_req;
  logic                 flush_done;
  logic                 busy;

  logic [WORD_SIZE-1:0] cache_addr;
  logic                 cache_readable;
  logic                 cache_writable;
  logic [WORD_SIZE-1:0] cache_wdata;
  logic [WORD_SIZE-1:0] cache_rdata;
  logic                 cache_hit;
  logic                 cache_flush;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, resp0_valid, resp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, resp1_valid, resp1_rdata,
    input  flush_req,
    output flush_done, busy,
    output cache_addr, cache_readable, cache_writable, cache_wdata, cache_flush,
    input  cache_rdata, cache_hit
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, resp0_valid, resp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, resp1_valid, resp1_rdata,
    output flush_req,
    input  flush_done, busy,
    input  cache_addr, cache_readable, cache_writable, cache_wdata, cache_flush,
    output cache_rdata, cache_hit
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter in front of a data cache, with miss wait
// and a timed whole-cache flush; one access or flush outstanding at a time.
module cache_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int MISS_LATENCY  = 8,
  parameter int FLUSH_LATENCY = 16
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, LOOKUP, MISS_WAIT, RESP, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic                 port_q, port_d;
  logic                 write_q, write_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata0_q, rdata0_d;
  logic [WORD_SIZE-1:0] rdata1_q, rdata1_d;

  logic                 grant;
  logic                 accept;
  logic [WORD_SIZE-1:0] cap_val;

  // Contention goes to the port that did not win last; a lone requester always wins.
  assign grant   = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign accept  = (state_q == IDLE) && !bus.flush_req && (bus.req0_valid || bus.req1_valid);
  assign cap_val = write_q ? '0 : bus.cache_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = 8'(FLUSH_LATENCY);
        end else if (accept) begin
          state_d      = ISSUE;
          last_grant_d = grant;
          port_d       = grant;
          write_d      = grant ? bus.req1_write : bus.req0_write;
          addr_d       = grant ? bus.req1_addr  : bus.req0_addr;
          wdata_d      = grant ? bus.req1_wdata : bus.req0_wdata;
        end
      end
      ISSUE: state_d = LOOKUP;
      LOOKUP: begin
        if (write_q || bus.cache_hit) begin
          state_d = RESP;
          if (port_q) rdata1_d = cap_val;
          else        rdata0_d = cap_val;
        end else begin
          state_d = MISS_WAIT;
          cnt_d   = 8'(MISS_LATENCY);
        end
      end
      MISS_WAIT: begin
        if (cnt_q == 8'd1) begin
          state_d = RESP;
          if (port_q) rdata1_d = cap_val;
          else        rdata0_d = cap_val;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: state_d = IDLE;
      FLUSH: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst so it is low for the whole reset interval.
  always_comb begin
    bus.req0_ready     = !rst && accept && !grant;
    bus.req1_ready     = !rst && accept && grant;
    bus.resp0_valid    = (state_q == RESP) && !port_q;
    bus.resp1_valid    = (state_q == RESP) && port_q;
    bus.resp0_rdata    = rdata0_q;
    bus.resp1_rdata    = rdata1_q;
    bus.busy           = (state_q != IDLE);
    bus.cache_addr     = addr_q;
    bus.cache_wdata    = wdata_q;
    bus.cache_readable = (state_q == ISSUE) && !write_q;
    bus.cache_writable = (state_q == ISSUE) && write_q;
    bus.cache_flush    = (state_q == FLUSH) && (cnt_q != 8'd0);
    bus.flush_done     = (state_q == FLUSH) && (cnt_q == 8'd0);
  end
endmodule
